piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter that sits directly upstream of the 4-bit serial-in shift register. It accepts WIDTH-bit words through a valid/ready handshake, buffers up to two pending words, and emits each word one bit per clock on `dout`. `dout` drives the shift register's `Din`. Back-to-back words are streamed with no idle gap, so the downstream register holds a complete word every WIDTH cycles.

---
 rtl/piso_serializer_pkg.sv | 6 +
 rtl/fifo2_buf.sv | 38 +++
 rtl/piso_serializer.sv | 70 +++++++
 tb/tb_piso_serializer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state enum and width constants for the serializer slice
package piso_serializer_pkg;
  typedef enum logic {IDLE, SHIFT} state_t;
  localparam int WORD_W = 4;
  localparam int CNT_W = 8;
endpackage

// File: rtl/fifo2_buf.sv
// fifo2_buf: 2-entry sync FIFO; ports clk, clr(async), push/wdata in, pop in, rdata/full/empty/count out
module fifo2_buf
  import piso_serializer_pkg::*;
#(
  parameter int W = WORD_W
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic wp, rp, do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rp];
  assign full = count == 2'd2;
  assign empty = count == 2'd0;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) mem[wp] <= wdata;
      if (do_push) wp <= ~wp;
      if (do_pop) rp <= ~rp;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready word in (din, load, ready), serial out (dout, dout_valid, last), status busy/words_sent; clk, async clr
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int   WIDTH      = WORD_W,
  parameter bit   MSB_FIRST  = 1'b1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] din,
  input  logic             load,
  output logic             ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LASTI = IW'(WIDTH - 1);
  state_t state, nxt;
  logic [WIDTH-1:0] sh, head;
  logic [IW-1:0] idx;
  logic [1:0] count;
  logic full, empty, endw, bnd, take, push, pop;
  fifo2_buf #(.W(WIDTH)) u_buf (
    .clk(clk),
    .clr(clr),
    .push(push),
    .pop(pop),
    .wdata(din),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign ready = count != 2'd2;
  assign endw = (state == SHIFT) && (idx == LASTI);
  assign bnd = (state == IDLE) | endw;
  assign take = bnd & (~empty | (load & ready));
  assign pop = bnd & ~empty;
  // at a word boundary with an empty buffer the accepted word goes straight to the shifter
  assign push = load & ~full & ~(bnd & empty);
  assign dout = state == SHIFT ? (MSB_FIRST ? sh[WIDTH-1] : sh[0]) : IDLE_LEVEL;
  assign dout_valid = state == SHIFT;
  assign last = endw;
  assign busy = (state == SHIFT) | ~empty;
  always_comb begin
    nxt = state;
    nxt = take ? SHIFT : (endw ? IDLE : state);
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      sh <= '0;
      idx <= '0;
      words_sent <= '0;
    end else begin
      if (take) sh <= empty ? din : head;
      else if (state == SHIFT) sh <= MSB_FIRST ? sh << 1 : sh >> 1;
      if (take || endw) idx <= '0;
      else if (state == SHIFT) idx <= idx + 1'b1;
      if (endw) words_sent <= words_sent + 1'b1;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: random and directed stimulus against a queue-based model, MSB- and LSB-first instances
module tb_piso_serializer;
  localparam int W = 4;
  logic clk = 1'b0, clr = 1'b1, load = 1'b0;
  logic [W-1:0] din = '0;
  logic m_ready, m_dout, m_valid, m_last, m_busy;
  logic l_ready, l_dout, l_valid, l_last, l_busy;
  logic [7:0] m_ws, l_ws;
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_msb (
    .clk(clk), .clr(clr), .din(din), .load(load), .ready(m_ready), .dout(m_dout),
    .dout_valid(m_valid), .last(m_last), .busy(m_busy), .words_sent(m_ws)
  );
  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk(clk), .clr(clr), .din(din), .load(load), .ready(l_ready), .dout(l_dout),
    .dout_valid(l_valid), .last(l_last), .busy(l_busy), .words_sent(l_ws)
  );
  always #5 clk = ~clk;
  int q[$];
  int cur = 0, pos = -1;
  logic [7:0] sent = '0;
  bit macc;
  int nchk = 0, nerr = 0;
  logic [W-1:0] wq[$];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int mbit(input bit msb);
    if (pos < 0) return 0;
    return msb ? (cur >> (W - 1 - pos)) & 1 : (cur >> pos) & 1;
  endfunction
  task automatic check_all();
    check("ready", {31'd0, m_ready}, {31'd0, q.size() < 2});
    check("lsb_ready", {31'd0, l_ready}, {31'd0, q.size() < 2});
    check("dout_msb", {31'd0, m_dout}, mbit(1));
    check("dout_lsb", {31'd0, l_dout}, mbit(0));
    check("valid", {31'd0, m_valid & l_valid}, {31'd0, pos >= 0});
    check("last", {31'd0, m_last & l_last}, {31'd0, pos == W - 1});
    check("busy", {31'd0, m_busy & l_busy}, {31'd0, pos >= 0 || q.size() > 0});
    check("words_sent", {24'd0, m_ws}, {24'd0, sent});
    check("lsb_words_sent", {24'd0, l_ws}, {24'd0, sent});
  endtask
  task automatic step();
    macc = load && q.size() < 2;
    if (macc) q.push_back(int'(din));
    if (pos < 0 || pos == W - 1) begin
      if (pos == W - 1) sent++;
      if (q.size() > 0) begin
        cur = q.pop_front();
        pos = 0;
      end else pos = -1;
    end else pos++;
  endtask
  task automatic cycle(input bit l, input logic [W-1:0] d);
    @(negedge clk);
    check_all();
    load = l;
    din = d;
    @(posedge clk);
    step();
  endtask
  task automatic idle(input int n);
    repeat (n) cycle(1'b0, W'($urandom));
  endtask
  task automatic burst();
    int guard = 0;
    while (wq.size() > 0 && guard < 100000) begin
      cycle(1'b1, wq[0]);
      if (macc) void'(wq.pop_front());
      guard++;
    end
    check("burst_drained", wq.size(), 0);
  endtask
  task automatic reset_mid();
    @(negedge clk);
    #1 clr = 1'b1;
    load = 1'b0;
    #1;
    q.delete();
    pos = -1;
    sent = '0;
    check_all();
    @(posedge clk);
    @(negedge clk);
    #1 clr = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all();
    clr = 1'b0;
    wq = '{4'b1011};
    burst();
    idle(6);
    wq = '{4'hA, 4'h5};
    burst();
    idle(10);
    wq = '{4'h1, 4'h2, 4'h3, 4'h4};
    burst();
    idle(20);
    wq = '{4'hF};
    burst();
    cycle(1'b0, 4'h0);
    reset_mid();
    idle(6);
    wq = '{4'b0001};
    burst();
    idle(6);
    reset_mid();
    for (int i = 0; i < 257; i++) wq.push_back(W'($urandom));
    burst();
    idle(10);
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) != 0, W'($urandom));
      if (i == 1500) reset_mid();
    end
    idle(20);
    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
